core_pc_ctrl: RTL and testbench
===============================

CORE_PC_CTRL -- requirements
Module: core_pc_ctrl

Interface
REQ-001 Parameter RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, 2, cycles IF/ID flush is held after a redirect (legal range 1-7).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 hold_flag_ex_in  in  1  execute-stage stall request.
REQ-006 jump_flag_ex_in  in  1  execute-stage redirect request.
REQ-007 jump_addr_ex_in  in  32  redirect target.
REQ-008 hold_flag_bus_in  in  1  external bus stall; freezes the whole front end.
REQ-009 pc_out  out  32  registered fetch address.
REQ-010 stall_pc_out  out  1  PC is not advancing this cycle.
REQ-011 stall_if_id_out  out  1  IF/ID register holds its value.
REQ-012 stall_id_ex_out  out  1  ID/EX register holds its value.
REQ-013 flush_if_id_out  out  1  IF/ID loads a bubble.
REQ-014 flush_id_ex_out  out  1  ID/EX loads a bubble.
REQ-015 state_out  out  2  FSM state: 0 RUN, 1 FLUSH, 2 BUS_HOLD.

Function
REQ-016 Registers: pc, state, flush counter cnt (3 bits), pending_valid, pending_addr (32); all other outputs are combinational from these registers and the inputs.
REQ-017 Priority per cycle: bus hold > jump > ex hold > sequential advance.
REQ-018 Effective target = {jump_addr_ex_in[31:2], 2'b00}; low bits are always cleared.
REQ-019 Sequential advance: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 Any state with hold_flag_bus_in=1: pc, cnt frozen; state <= BUS_HOLD; stall_pc/stall_if_id/stall_id_ex = 1; both flushes = 0.
REQ-021 During bus hold, jump_flag_ex_in=1 sets pending_valid=1 and pending_addr=target; a later jump in the same hold overwrites pending_addr.
REQ-022 BUS_HOLD exit (hold_flag_bus_in=0): if pending_valid, pc <= pending_addr, pending_valid <= 0, cnt <= FLUSH_CYCLES-1, state <= FLUSH (or RUN if FLUSH_CYCLES=1), and flush_if_id_out=flush_id_ex_out=1 that cycle; else state <= FLUSH if cnt!=0, else RUN, and normal rules apply that cycle.
REQ-023 RUN/FLUSH with jump_flag_ex_in=1: pc <= target; flush_if_id_out=flush_id_ex_out=1 same cycle; cnt <= FLUSH_CYCLES-1; state <= FLUSH if FLUSH_CYCLES>1, else RUN; ex hold ignored that cycle.
REQ-024 RUN/FLUSH with hold_flag_ex_in=1, no jump: pc frozen; stall_pc=stall_if_id=1; flush_id_ex_out=1; stall_id_ex=0.
REQ-025 FLUSH without jump: flush_if_id_out=1; cnt decrements each non-bus-hold cycle; state <= RUN when cnt reaches 0 (cnt==1 -> RUN next).
REQ-026 A jump arriving in FLUSH reloads cnt and redirects again (no merge with prior count).
REQ-027 stall_* and flush_* on the same register are never both 1.

Reset
REQ-028 On rst=0, immediately: pc=RESET_ADDR, state=RUN, cnt=0, pending_valid=0, pending_addr=0; stalls and flushes=0 while rst=0.
REQ-029 First edge after rst rises: pc <= RESET_ADDR+4; reset asserted mid-hold or mid-flush discards pending jump and counter.

Verification
REQ-030 Reset release, no stimulus, 4 clocks -> pc_out 0,4,8,12,16; all stall/flush 0; state_out 0.
REQ-031 pc=0x100, jump_flag=1, jump_addr=0x203 one cycle -> same cycle both flushes 1; next pc=0x200, state 1, flush_if_id 1 for 1 more cycle, then pc 0x204, state 0.
REQ-032 pc=0x40, hold_flag_ex=1 for 3 cycles -> pc stays 0x40, stall_if_id=1, flush_id_ex=1 each cycle; then pc 0x44.
REQ-033 bus hold 4 cycles with jump to 0x800 in cycle 2 and 0x900 in cycle 3 -> pc frozen, state 2, flushes 0; on release pc=0x900, both flushes 1, state 1.
REQ-034 pc=0xFFFF_FFFC, no hold -> next pc 0x0000_0000.
REQ-035 rst pulled low during FLUSH with pending jump -> pc=RESET_ADDR asynchronously, state 0, pending cleared; after release pc advances from RESET_ADDR.

Source files
------------

// File: rtl/core_pc_ctrl.sv
// core_pc_ctrl: fetch PC register and front-end pipeline control.
// Chooses between sequential advance, EX-stage redirects and stalls, and
// external bus holds. Drives the stall/flush controls for IF/ID and ID/EX.
//
// state     | meaning
// ----------|------------------------------------------------------------
// RUN       | normal fetch, pc advances by 4 unless EX holds
// FLUSH     | a redirect happened; IF/ID still holds wrong-path fetches
// BUS_HOLD  | bus stall; front end frozen, EX redirects parked as pending
module core_pc_ctrl #(
  parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_flag_ex_in,
  input  logic        jump_flag_ex_in,
  input  logic [31:0] jump_addr_ex_in,
  input  logic        hold_flag_bus_in,
  output logic [31:0] pc_out,
  output logic        stall_pc_out,
  output logic        stall_if_id_out,
  output logic        stall_id_ex_out,
  output logic        flush_if_id_out,
  output logic        flush_id_ex_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_BUS_HOLD = 2'd2
  } state_t;

  // Counter value loaded on a redirect; the redirect cycle itself is the
  // first flush cycle, so FLUSH_CYCLES-1 further cycles remain.
  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_t     JUMP_STATE = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  logic [31:0] pc;
  state_t      state;
  logic [2:0]  cnt;
  logic        pending_valid;
  logic [31:0] pending_addr;

  logic [31:0] target;
  logic        bus_hold;
  logic        take_pending;
  logic        in_flush;
  logic        do_jump;
  logic        do_ex_hold;
  logic        do_flush_step;

  assign target = {jump_addr_ex_in[31:2], 2'b00};

  // Per-cycle action decode in priority order: bus hold, parked redirect,
  // jump, EX hold, sequential advance.
  always_comb begin
    bus_hold      = hold_flag_bus_in;
    take_pending  = !bus_hold && (state == ST_BUS_HOLD) && pending_valid;
    // Leaving a bus hold without a parked redirect resumes whatever flush
    // was in progress when the hold began (cnt was frozen).
    in_flush      = (state == ST_FLUSH) || ((state == ST_BUS_HOLD) && (cnt != 3'd0));
    do_jump       = !bus_hold && !take_pending && jump_flag_ex_in;
    do_ex_hold    = !bus_hold && !take_pending && !jump_flag_ex_in && hold_flag_ex_in;
    do_flush_step = !bus_hold && !take_pending && !jump_flag_ex_in && in_flush;
  end

  // Pipeline control outputs; all forced low while reset is asserted.
  // During a flush with an EX hold, IF/ID keeps flushing (its content is
  // wrong-path) instead of stalling, so stall and flush never collide.
  always_comb begin
    stall_pc_out    = 1'b0;
    stall_if_id_out = 1'b0;
    stall_id_ex_out = 1'b0;
    flush_if_id_out = 1'b0;
    flush_id_ex_out = 1'b0;
    if (rst) begin
      stall_pc_out    = bus_hold || do_ex_hold;
      stall_if_id_out = bus_hold || (do_ex_hold && !in_flush);
      stall_id_ex_out = bus_hold;
      flush_if_id_out = take_pending || do_jump || do_flush_step;
      flush_id_ex_out = take_pending || do_jump || do_ex_hold;
    end
  end

  assign pc_out    = pc;
  assign state_out = state;

  // PC, FSM state, flush counter and parked-redirect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_ADDR;
      state         <= ST_RUN;
      cnt           <= 3'd0;
      pending_valid <= 1'b0;
      pending_addr  <= 32'h0000_0000;
    end else if (bus_hold) begin
      state <= ST_BUS_HOLD;
      if (jump_flag_ex_in) begin
        pending_valid <= 1'b1;
        pending_addr  <= target;
      end
    end else if (take_pending) begin
      pc            <= pending_addr;
      pending_valid <= 1'b0;
      cnt           <= CNT_RELOAD;
      state         <= JUMP_STATE;
    end else if (do_jump) begin
      pc    <= target;
      cnt   <= CNT_RELOAD;
      state <= JUMP_STATE;
    end else begin
      if (!do_ex_hold) begin
        pc <= pc + 32'd4;
      end
      if (in_flush) begin
        if (cnt != 3'd0) begin
          cnt <= cnt - 3'd1;
        end
        state <= (cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
      end else begin
        state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_core_pc_ctrl.sv
// Directed bench for core_pc_ctrl with hand-computed expectations.
module tb_core_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        hold_flag_ex_in;
  logic        jump_flag_ex_in;
  logic [31:0] jump_addr_ex_in;
  logic        hold_flag_bus_in;
  logic [31:0] pc_out;
  logic        stall_pc_out;
  logic        stall_if_id_out;
  logic        stall_id_ex_out;
  logic        flush_if_id_out;
  logic        flush_id_ex_out;
  logic [1:0]  state_out;

  int n_cmp = 0;
  int n_err = 0;

  core_pc_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .hold_flag_ex_in  (hold_flag_ex_in),
    .jump_flag_ex_in  (jump_flag_ex_in),
    .jump_addr_ex_in  (jump_addr_ex_in),
    .hold_flag_bus_in (hold_flag_bus_in),
    .pc_out           (pc_out),
    .stall_pc_out     (stall_pc_out),
    .stall_if_id_out  (stall_if_id_out),
    .stall_id_ex_out  (stall_id_ex_out),
    .flush_if_id_out  (flush_if_id_out),
    .flush_id_ex_out  (flush_id_ex_out),
    .state_out        (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk({tag, ".ctl"}, {stall_pc_out, stall_if_id_out, stall_id_ex_out,
                        flush_if_id_out, flush_id_ex_out}, exp);
  endtask

  initial begin
    rst              = 1'b0;
    hold_flag_ex_in  = 1'b0;
    jump_flag_ex_in  = 1'b0;
    jump_addr_ex_in  = 32'h0;
    hold_flag_bus_in = 1'b1;
    #3;
    chk("rst.pc", pc_out, 32'h0);
    chk("rst.state", state_out, 2'd0);
    chk_ctl("rst", 5'b00000);
    @(negedge clk);
    hold_flag_bus_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel.pc0", pc_out, 32'h0);
    chk_ctl("rel0", 5'b00000);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("seq.pc%0d", i), pc_out, 32'(4 * i));
      chk($sformatf("seq.st%0d", i), state_out, 2'd0);
      chk_ctl($sformatf("seq%0d", i), 5'b00000);
    end

    // Redirect to 0xFC (low bits cleared), flush, land at 0x100
    jump_flag_ex_in = 1'b1;
    jump_addr_ex_in = 32'h0000_00FF;
    #1;
    chk_ctl("j0", 5'b00011);
    step();
    jump_flag_ex_in = 1'b0;
    #1;
    chk("j0.pc", pc_out, 32'hFC);
    chk("j0.st", state_out, 2'd1);
    step();
    chk("j0.pc2", pc_out, 32'h100);
    chk("j0.st2", state_out, 2'd0);

    // Jump at pc 0x100 to 0x203
    jump_flag_ex_in = 1'b1;
    jump_addr_ex_in = 32'h0000_0203;
    #1;
    chk_ctl("j1", 5'b00011);
    step();
    jump_flag_ex_in = 1'b0;
    #1;
    chk("j1.pc", pc_out, 32'h200);
    chk("j1.st", state_out, 2'd1);
    chk_ctl("j1.fl", 5'b00010);
    step();
    chk("j1.pc2", pc_out, 32'h204);
    chk("j1.st2", state_out, 2'd0);
    chk_ctl("j1.run", 5'b00000);

    // Get to 0x40, then EX hold for 3 cycles
    jump_flag_ex_in = 1'b1;
    jump_addr_ex_in = 32'h0000_003C;
    step();
    jump_flag_ex_in = 1'b0;
    step();
    chk("exh.pc0", pc_out, 32'h40);
    hold_flag_ex_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("exh.pc%0d", i), pc_out, 32'h40);
      chk_ctl($sformatf("exh%0d", i), 5'b11001);
      step();
    end
    hold_flag_ex_in = 1'b0;
    #1;
    chk("exh.pc3", pc_out, 32'h40);
    chk_ctl("exh.rel", 5'b00000);
    step();
    chk("exh.pc4", pc_out, 32'h44);

    // Bus hold 4 cycles, jumps to 0x800 (cycle 2) and 0x900 (cycle 3)
    hold_flag_bus_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      jump_flag_ex_in = (i == 2) || (i == 3);
      jump_addr_ex_in = (i == 2) ? 32'h800 : 32'h900;
      #1;
      chk($sformatf("bus.pc%0d", i), pc_out, 32'h44);
      chk_ctl($sformatf("bus%0d", i), 5'b11100);
      if (i > 1) chk($sformatf("bus.st%0d", i), state_out, 2'd2);
      step();
    end
    hold_flag_bus_in = 1'b0;
    jump_flag_ex_in  = 1'b0;
    #1;
    chk("bus.rel.st", state_out, 2'd2);
    chk("bus.rel.pc", pc_out, 32'h44);
    chk_ctl("bus.rel", 5'b00011);
    step();
    chk("bus.pc", pc_out, 32'h900);
    chk("bus.st", state_out, 2'd1);
    chk_ctl("bus.fl", 5'b00010);
    step();
    chk("bus.pc2", pc_out, 32'h904);
    chk("bus.st2", state_out, 2'd0);

    // Wrap at top of address space
    jump_flag_ex_in = 1'b1;
    jump_addr_ex_in = 32'hFFFF_FFF8;
    step();
    jump_flag_ex_in = 1'b0;
    step();
    chk("wrap.pc0", pc_out, 32'hFFFF_FFFC);
    step();
    chk("wrap.pc1", pc_out, 32'h0);

    // Reset mid-flush with a parked redirect
    jump_flag_ex_in = 1'b1;
    jump_addr_ex_in = 32'h300;
    step();
    jump_addr_ex_in  = 32'h500;
    hold_flag_bus_in = 1'b1;
    step();
    chk("mid.st", state_out, 2'd2);
    chk("mid.pc", pc_out, 32'h300);
    rst = 1'b0;
    #1;
    chk("arst.pc", pc_out, 32'h0);
    chk("arst.st", state_out, 2'd0);
    chk_ctl("arst", 5'b00000);
    jump_flag_ex_in  = 1'b0;
    hold_flag_bus_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post.pc", pc_out, 32'h4);
    chk("post.st", state_out, 2'd0);
    chk_ctl("post", 5'b00000);
    step();
    chk("post.pc2", pc_out, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
